im_load_sequencer: RTL and testbench

- Parametrised successor to the instruction-load counter.
- Accepts a stream of instruction words over a valid/ready handshake and writes them into the instruction memory (IM) starting at a programmable base address.
- Counts loaded words and signals completion, abort and range errors.
- Sits between the load-control state machine and the IM write port.

---
 rtl/im_load_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_im_load_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_load_sequencer.sv
// ---------------------------------------------------------------------------
// im_load_sequencer
//
// Purpose:
//   Streams instruction words from an upstream valid/ready source into the
//   instruction memory (IM), starting at a programmable base address. It
//   counts accepted words and reports completion, abort and range errors.
//   It sits between the load-control state machine and the IM write port.
//
// Handshake:
//   A word transfers on a rising edge where in_valid & in_ready are both 1.
//   in_ready is driven only from the registered state (high in LOAD), with
//   no combinational path from in_valid. The upstream side must hold
//   in_data stable while in_valid is high and in_ready is low.
//
// Ports:
//   clk        in   clock, rising-edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a load (sampled only in IDLE)
//   abort      in   terminate a load in progress (LOAD only)
//   base       in   [ADDR_W-1:0] first IM address, sampled with start
//   len        in   [ADDR_W:0]   number of words, sampled with start
//   in_valid   in   upstream word valid
//   in_data    in   [DATA_W-1:0] upstream instruction word
//   in_ready   out  sequencer accepts a word this cycle
//   im_we      out  IM write strobe (one cycle after each handshake)
//   im_addr    out  [ADDR_W-1:0] IM write address
//   im_wdata   out  [DATA_W-1:0] IM write data
//   cuenta     out  [ADDR_W:0]   words accepted in the current/last load
//   busy       out  high in LOAD
//   done       out  one-cycle pulse on successful completion
//   err        out  one-cycle pulse on a rejected start
//   state_o    out  [1:0] current FSM state (debug visibility)
//   stall_cnt  out  [15:0] LOAD cycles without in_valid (optional)
//
// Optional feature:
//   Define IMLC_STALL_CNT_EN to add the stall_cnt output and its saturating
//   counter. Without it the port and counter are absent.
// ---------------------------------------------------------------------------
module im_load_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic [ADDR_W:0]   cuenta,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_o
`ifdef IMLC_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // DEPTH extended to the width of the range check so that base+len
    // cannot overflow before the comparison.
    localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     cuenta_q, cuenta_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [DATA_W-1:0]   im_wdata_q, im_wdata_d;
    logic                err_q, err_d;

    logic [ADDR_W+1:0]   end_addr;
    logic                range_bad;
    logic                hs;
    logic [ADDR_W:0]     cuenta_inc;

    // Range check for a start request, done at ADDR_W+2 bits.
    assign end_addr  = {2'b00, base} + {1'b0, len};
    assign range_bad = (len == '0) || (end_addr > DEPTH_L);

    // A handshake that coincides with abort is dropped.
    assign hs         = (state_q == S_LOAD) && in_valid && !abort;
    assign cuenta_inc = cuenta_q + ONE_C;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cuenta_q   <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cuenta_q   <= cuenta_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            err_q      <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cuenta_d   = cuenta_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        base_d   = base;
                        len_d    = len;
                        cuenta_d = '0;
                        state_d  = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (abort) begin
                    // Words already written stay counted in cuenta.
                    state_d = S_IDLE;
                end else if (hs) begin
                    im_we_d    = 1'b1;
                    // Address wraps modulo 2^ADDR_W by truncation.
                    im_addr_d  = base_q + cuenta_q[ADDR_W-1:0];
                    im_wdata_d = in_data;
                    cuenta_d   = cuenta_inc;
                    if (cuenta_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef IMLC_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start && !range_bad) begin
            stall_d = '0;
        end else if (state_q == S_LOAD && !in_valid && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD);
    // done is asserted for the whole DONE cycle, which coincides with the
    // final IM write.
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cuenta   = cuenta_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_im_load_sequencer.sv
module tb_im_load_sequencer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int EW     = ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic [ADDR_W:0]   cuenta;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        state_o;
`ifdef IMLC_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];

    im_load_sequencer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .base     (base),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cuenta   (cuenta),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .state_o  (state_o)
`ifdef IMLC_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word for the next edge and record the write it must cause.
    task automatic put_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        in_valid = 1'b1;
        in_data  = data;
        exp_q.push_back({addr, data});
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    // Scoreboard: every IM write must match the oldest expected entry.
    always @(posedge clk) begin
        #2;
        if (im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {1'b1, im_addr, im_wdata}, '0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", 64'(im_addr), 64'(e[EW-1:DATA_W]));
                check("write_data", 64'(im_wdata), 64'(e[DATA_W-1:0]));
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] d;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        base     = '0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset values
        #1;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_busy",     64'(busy),     0);
        check("rst_done",     64'(done),     0);
        check("rst_err",      64'(err),      0);
        check("rst_im_we",    64'(im_we),    0);
        check("rst_im_addr",  64'(im_addr),  0);
        check("rst_im_wdata", 64'(im_wdata), 0);
        check("rst_cuenta",   64'(cuenta),   0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic load: base=4, len=3, in_valid held high
        start = 1'b1; base = 6'd4; len = 7'd3;
        tick();
        start = 1'b0;
        check("t1_busy", 64'(busy), 1);
        check("t1_cuenta_clear", 64'(cuenta), 0);
        for (int i = 0; i < 3; i++) begin
            check("t1_in_ready", 64'(in_ready), 1);
            check("t1_no_done", 64'(done), 0);
            put_word(6'(4 + i), 32'hA0A0_0000 + 32'(i));
            tick();
        end
        check("t1_done",      64'(done),     1);
        check("t1_cuenta",    64'(cuenta),   3);
        check("t1_busy_fall", 64'(busy),     0);
        check("t1_ready_low", 64'(in_ready), 0);
        idle_in();
        tick();
        check("t1_done_pulse", 64'(done), 0);
        check("t1_we_low",     64'(im_we), 0);

        // Rejected starts: len=0, then base=62 len=3; in_valid high throughout
        in_valid = 1'b1;
        start = 1'b1; base = 6'd0; len = 7'd0;
        tick();
        start = 1'b0;
        check("t2a_err",    64'(err),    1);
        check("t2a_busy",   64'(busy),   0);
        check("t2a_cuenta", 64'(cuenta), 3);
        tick();
        check("t2a_err_pulse", 64'(err),  0);
        check("t2a_busy2",     64'(busy), 0);
        start = 1'b1; base = 6'd62; len = 7'd3;
        tick();
        start = 1'b0;
        check("t2b_err",  64'(err),  1);
        check("t2b_busy", 64'(busy), 0);
        tick();
        check("t2b_err_pulse", 64'(err),  0);
        check("t2b_busy2",     64'(busy), 0);
        idle_in();
        tick();

        // Toggling in_valid: base=0, len=4, pattern 1,0,1,0,1,0,1
        start = 1'b1; base = 6'd0; len = 7'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) begin
                put_word(6'(i / 2), $urandom());
            end else begin
                idle_in();
            end
            tick();
            check("t3_done", 64'(done), (i == 6) ? 64'd1 : 64'd0);
        end
        check("t3_cuenta", 64'(cuenta), 4);
`ifdef IMLC_STALL_CNT_EN
        check("t3_stall_cnt", 64'(stall_cnt), 3);
`endif
        idle_in();
        tick();

        // Abort with the 3rd handshake: base=10, len=8
        start = 1'b1; base = 6'd10; len = 7'd8;
        tick();
        start = 1'b0;
        put_word(6'd10, $urandom());
        tick();
        put_word(6'd11, $urandom());
        tick();
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        idle_in();
        check("t4_busy",     64'(busy),    0);
        check("t4_state",    64'(state_o), 0);
        check("t4_done",     64'(done),    0);
        check("t4_cuenta",   64'(cuenta),  2);
        check("t4_we_drop",  64'(im_we),   0);
        tick();
        check("t4_done_late", 64'(done), 0);

        // Asynchronous reset in the middle of a load
        start = 1'b1; base = 6'd20; len = 7'd5;
        tick();
        start = 1'b0;
        put_word(6'd20, $urandom());
        tick();
        idle_in();
        #3;
        rst = 1'b1;
        #1;
        check("t5_in_ready", 64'(in_ready), 0);
        check("t5_busy",     64'(busy),     0);
        check("t5_im_we",    64'(im_we),    0);
        check("t5_im_addr",  64'(im_addr),  0);
        check("t5_im_wdata", 64'(im_wdata), 0);
        check("t5_cuenta",   64'(cuenta),   0);
        check("t5_done",     64'(done),     0);
        #2;
        rst = 1'b0;
        tick();
        start = 1'b1; base = 6'd0; len = 7'd1;
        tick();
        start = 1'b0;
        check("t5_restart_busy", 64'(busy), 1);
        d = $urandom();
        put_word(6'd0, d);
        tick();
        check("t5_done2",   64'(done),   1);
        check("t5_cuenta2", 64'(cuenta), 1);
        idle_in();
        tick();

        // Top-of-memory load, start ignored in DONE, accepted right after
        start = 1'b1; base = 6'd60; len = 7'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put_word(6'(60 + i), $urandom());
            tick();
        end
        check("t6_done",   64'(done),   1);
        check("t6_cuenta", 64'(cuenta), 4);
        idle_in();
        start = 1'b1; base = 6'd0; len = 7'd2;
        tick();
        check("t6_start_in_done_ignored", 64'(busy), 0);
        check("t6_idle", 64'(state_o), 0);
        check("t6_no_err", 64'(err), 0);
        tick();
        start = 1'b0;
        check("t6_restart_busy",   64'(busy),   1);
        check("t6_restart_cuenta", 64'(cuenta), 0);
        put_word(6'd0, $urandom());
        tick();
        put_word(6'd1, $urandom());
        tick();
        check("t6_done2",   64'(done),   1);
        check("t6_cuenta2", 64'(cuenta), 2);
        idle_in();
        tick();
        tick();

        check("sb_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
